tlb_unit: RTL and testbench

Fully-associative 16-entry joint TLB for the MIPS core, answering coprocessor 0's translation-management requests. It provides:
- the probe search (TLBP),
- indexed read (TLBR),
- indexed and random write (TLBWI/TLBWR),
- two independent translation lookups for the fetch and memory stages.

After reset, a built-in sequencer invalidates every entry. Lookups report miss until that sweep completes.

---
 rtl/tlb_params.sv | 40 ++++
 rtl/tlb_unit_if.sv | 32 +++
 rtl/tlb_search_port.sv | 51 +++++
 rtl/tlb_unit.sv | 94 +++++++++
 tb/tb_tlb_unit.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_params.sv
// Shared TLB types and sizing.
// TLB_NUM is the entry count (power of two); IW is the index width.
package tlb_params;

    localparam int unsigned TLB_NUM = 16;
    localparam int unsigned IW      = $clog2(TLB_NUM);

    typedef enum logic [0:0] {StClear, StReady} tlb_state_e;

    typedef struct packed {
        logic [18:0] virtual_page_number;
        logic        is_odd_page;
        logic [7:0]  asid;
    } search_request_t;

    typedef struct packed {
        logic          found;
        logic [IW-1:0] index;
        logic [19:0]   page_frame_number;
        logic [2:0]    is_cached;
        logic          is_dirty;
        logic          is_valid;
    } search_result_t;

    typedef struct packed {
        logic [19:0] page_frame_number;
        logic [2:0]  is_cached;
        logic        is_dirty;
        logic        is_valid;
    } page_t;

    typedef struct packed {
        logic [18:0] virtual_page_number;
        logic [7:0]  asid;
        logic        is_global;
        page_t       even_page;
        page_t       odd_page;
    } tlb_request_t;

endpackage

// File: rtl/tlb_unit_if.sv
// Request/result bundle between the core/CP0 (master) and the TLB (slave).
// Carries the three search ports, TLBR read, TLBWI/TLBWR write, Random and busy.
interface tlb_unit_if;
    import tlb_params::*;

    search_request_t fetch_request;
    search_result_t  fetch_result;
    search_request_t data_request;
    search_result_t  data_result;
    search_request_t probe_request;
    search_result_t  probe_result;
    logic [IW-1:0]   read_index;
    tlb_request_t    read_data;
    logic            write_enable;
    logic            write_use_random;
    logic [IW-1:0]   write_index;
    tlb_request_t    write_data;
    logic [IW-1:0]   random_index;
    logic            busy;

    modport slave (
        input  fetch_request, data_request, probe_request, read_index,
               write_enable, write_use_random, write_index, write_data,
        output fetch_result, data_result, probe_result, read_data, random_index, busy
    );

    modport master (
        output fetch_request, data_request, probe_request, read_index,
               write_enable, write_use_random, write_index, write_data,
        input  fetch_result, data_result, probe_result, read_data, random_index, busy
    );
endinterface

// File: rtl/tlb_search_port.sv
// One combinational TLB search port.
// entries: full array image; busy: suppresses hits; request/result: lookup in/out.
module tlb_search_port
    import tlb_params::*;
(
    input  tlb_request_t    entries [TLB_NUM],
    input  logic            busy,
    input  search_request_t request,
    output search_result_t  result
);

    logic [TLB_NUM-1:0] entry_match;
    logic               hit;
    logic [IW-1:0]      hit_index;
    page_t              page;

    always_comb begin
        entry_match = '0;
        for (int i = 0; i < int'(TLB_NUM); i++) begin
            entry_match[i] = (entries[i].virtual_page_number == request.virtual_page_number) &&
                             (entries[i].is_global || (entries[i].asid == request.asid));
        end
    end

    // Scan downwards so the lowest matching index is the last one assigned.
    always_comb begin
        hit       = 1'b0;
        hit_index = '0;
        for (int i = int'(TLB_NUM) - 1; i >= 0; i--) begin
            if (entry_match[i]) begin
                hit       = 1'b1;
                hit_index = IW'(i);
            end
        end
    end

    always_comb begin
        page   = request.is_odd_page ? entries[hit_index].odd_page
                                     : entries[hit_index].even_page;
        result = '0;
        if (hit && !busy) begin
            result.found             = 1'b1;
            result.index             = hit_index;
            result.page_frame_number = page.page_frame_number;
            result.is_cached         = page.is_cached;
            result.is_dirty          = page.is_dirty;
            result.is_valid          = page.is_valid;
        end
    end

endmodule

// File: rtl/tlb_unit.sv
// 16-entry fully-associative joint TLB.
// clock/reset: sole clock, synchronous active-low reset.
// bus: fetch/data/probe searches, TLBR read, TLBWI/TLBWR write, Random, busy.
// After reset an invalidation sweep clears every entry; writes are dropped meanwhile.
module tlb_unit
    import tlb_params::*;
(
    input  logic       clock,
    input  logic       reset,
    tlb_unit_if.slave  bus
);

    tlb_state_e    state_q, state_d;
    logic [IW-1:0] sweep_q, sweep_d;
    logic [IW-1:0] random_q, random_d;
    tlb_request_t  entries_q [TLB_NUM];

    logic          entry_we;
    logic [IW-1:0] entry_idx;
    tlb_request_t  entry_wdata;

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        random_d    = random_q;
        entry_we    = 1'b0;
        entry_idx   = sweep_q;
        entry_wdata = '0;
        unique case (state_q)
            StClear: begin
                entry_we = 1'b1;
                sweep_d  = sweep_q + 1'b1;
                if (sweep_q == IW'(TLB_NUM - 1)) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                // Power-of-two size: natural wrap gives 0 -> TLB_NUM-1.
                random_d = random_q - 1'b1;
                if (bus.write_enable) begin
                    entry_we    = 1'b1;
                    // Pre-decrement Random is used for TLBWR.
                    entry_idx   = bus.write_use_random ? random_q : bus.write_index;
                    entry_wdata = bus.write_data;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= StClear;
            sweep_q  <= '0;
            random_q <= IW'(TLB_NUM - 1);
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            random_q <= random_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && entry_we) begin
            entries_q[entry_idx] <= entry_wdata;
        end
    end

    assign bus.busy         = (state_q == StClear);
    assign bus.random_index = random_q;
    assign bus.read_data    = entries_q[bus.read_index];

    tlb_search_port u_fetch (
        .entries (entries_q),
        .busy    (bus.busy),
        .request (bus.fetch_request),
        .result  (bus.fetch_result)
    );

    tlb_search_port u_data (
        .entries (entries_q),
        .busy    (bus.busy),
        .request (bus.data_request),
        .result  (bus.data_result)
    );

    tlb_search_port u_probe (
        .entries (entries_q),
        .busy    (bus.busy),
        .request (bus.probe_request),
        .result  (bus.probe_result)
    );

endmodule

// File: tb/tb_tlb_unit.sv
module tb_tlb_unit;
    import tlb_params::*;

    localparam int KProbe  = 0;
    localparam int KFetch  = 1;
    localparam int KData   = 2;
    localparam int KRead   = 3;
    localparam int KRandom = 4;
    localparam int KBusy   = 5;

    typedef struct {
        string        name;
        int           kind;
        logic [127:0] val;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    tlb_unit_if bus ();

    tlb_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t         exp_q[$];
    int           total = 0;
    int           bad   = 0;
    logic [IW-1:0] exp_rand;
    logic          model_ready = 1'b0;

    tlb_request_t e5, e2, e3, e7, e9, e1;
    search_result_t miss;

    function automatic page_t mk_page(input logic [19:0] pfn, input logic [2:0] c,
                                      input logic d, input logic v);
        page_t p;
        p.page_frame_number = pfn;
        p.is_cached         = c;
        p.is_dirty          = d;
        p.is_valid          = v;
        return p;
    endfunction

    function automatic tlb_request_t mk_entry(input logic [18:0] vpn, input logic [7:0] asid,
                                              input logic g, input page_t ev, input page_t od);
        tlb_request_t e;
        e.virtual_page_number = vpn;
        e.asid                = asid;
        e.is_global           = g;
        e.even_page           = ev;
        e.odd_page            = od;
        return e;
    endfunction

    function automatic search_request_t mk_req(input logic [18:0] vpn, input logic odd,
                                               input logic [7:0] asid);
        search_request_t r;
        r.virtual_page_number = vpn;
        r.is_odd_page         = odd;
        r.asid                = asid;
        return r;
    endfunction

    function automatic search_result_t mk_hit(input logic [IW-1:0] idx, input page_t p);
        search_result_t r;
        r.found             = 1'b1;
        r.index             = idx;
        r.page_frame_number = p.page_frame_number;
        r.is_cached         = p.is_cached;
        r.is_dirty          = p.is_dirty;
        r.is_valid          = p.is_valid;
        return r;
    endfunction

    task automatic push(input string name, input int kind, input logic [127:0] val);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic expect_res(input string name, input int kind, input search_result_t r);
        logic [127:0] v;
        v = '0;
        v[$bits(search_result_t)-1:0] = r;
        push(name, kind, v);
    endtask

    task automatic expect_entry(input string name, input tlb_request_t e);
        logic [127:0] v;
        v = '0;
        v[$bits(tlb_request_t)-1:0] = e;
        push(name, KRead, v);
    endtask

    task automatic expect_scalar(input string name, input int kind, input logic [IW-1:0] x);
        logic [127:0] v;
        v = '0;
        v[IW-1:0] = x;
        push(name, kind, v);
    endtask

    task automatic tick();
        @(posedge clock);
        if (model_ready) exp_rand = exp_rand - 1'b1;
        #1;
    endtask

    function automatic logic [127:0] actual_of(input int kind);
        logic [127:0] v;
        v = '0;
        case (kind)
            KProbe:  v[$bits(search_result_t)-1:0] = bus.probe_result;
            KFetch:  v[$bits(search_result_t)-1:0] = bus.fetch_result;
            KData:   v[$bits(search_result_t)-1:0] = bus.data_result;
            KRead:   v[$bits(tlb_request_t)-1:0]   = bus.read_data;
            KRandom: v[IW-1:0]                      = bus.random_index;
            default: v[0]                           = bus.busy;
        endcase
        return v;
    endfunction

    // Monitor: compares every queued expectation against the outputs of that cycle.
    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [127:0] act;
            e   = exp_q.pop_front();
            act = actual_of(e.kind);
            total++;
            if (act !== e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, act, e.val);
            end
        end
    end

    initial begin
        miss = '0;
        e5 = mk_entry(19'h12345, 8'h3A, 1'b0, mk_page(20'h00ABC, 3'd3, 1'b0, 1'b1),
                      mk_page(20'h00DEF, 3'd3, 1'b1, 1'b1));
        e2 = mk_entry(19'h00777, 8'h11, 1'b1, mk_page(20'h11111, 3'd2, 1'b0, 1'b1),
                      mk_page(20'h22222, 3'd2, 1'b0, 1'b0));
        e3 = mk_entry(19'h00777, 8'h55, 1'b0, mk_page(20'h33333, 3'd3, 1'b0, 1'b1),
                      mk_page(20'h44444, 3'd3, 1'b1, 1'b1));
        e7 = mk_entry(19'h07007, 8'h07, 1'b0, mk_page(20'h70000, 3'd1, 1'b1, 1'b1),
                      mk_page(20'h70001, 3'd1, 1'b0, 1'b1));
        e9 = mk_entry(19'h09009, 8'h09, 1'b1, mk_page(20'h90000, 3'd5, 1'b0, 1'b1),
                      mk_page(20'h90001, 3'd5, 1'b1, 1'b0));
        e1 = mk_entry(19'h01001, 8'h01, 1'b1, mk_page(20'h10000, 3'd3, 1'b0, 1'b1),
                      mk_page(20'h10001, 3'd3, 1'b0, 1'b1));

        reset                = 1'b0;
        bus.fetch_request    = '0;
        bus.data_request     = '0;
        bus.probe_request    = '0;
        bus.read_index       = '0;
        bus.write_enable     = 1'b0;
        bus.write_use_random = 1'b0;
        bus.write_index      = '0;
        bus.write_data       = '0;
        exp_rand             = IW'(TLB_NUM - 1);

        tick();
        tick();
        expect_scalar("reset_busy", KBusy, 1);
        expect_scalar("reset_random", KRandom, 4'd15);
        expect_res("reset_probe", KProbe, miss);
        reset = 1'b1;

        // Sweep: busy for exactly 16 cycles after release.
        for (int i = 0; i < 16; i++) begin
            expect_scalar("sweep_busy", KBusy, 1);
            if (i == 4) expect_res("sweep_probe_vpn0", KProbe, miss);
            tick();
        end
        expect_scalar("sweep_done", KBusy, 0);
        exp_rand    = IW'(TLB_NUM - 1);
        model_ready = 1'b1;

        // Random counts down 15..0 then wraps to 15.
        for (int i = 0; i < 17; i++) begin
            expect_scalar("random_count", KRandom, exp_rand);
            tick();
        end

        // TLBWI index 5; same-cycle read sees old (cleared) contents.
        bus.write_enable = 1'b1;
        bus.write_index  = 4'd5;
        bus.write_data   = e5;
        bus.read_index   = 4'd5;
        expect_entry("wi5_old_read", '0);
        tick();
        bus.write_enable  = 1'b0;
        bus.probe_request = mk_req(19'h12345, 1'b0, 8'h3A);
        bus.data_request  = mk_req(19'h12345, 1'b1, 8'h3A);
        bus.fetch_request = mk_req(19'h12345, 1'b0, 8'h3B);
        expect_res("probe_e5", KProbe, mk_hit(4'd5, e5.even_page));
        expect_res("data_e5_odd", KData, mk_hit(4'd5, e5.odd_page));
        expect_res("fetch_e5_wrong_asid", KFetch, miss);
        expect_entry("wi5_new_read", e5);
        tick();

        // Global entry at 2, non-global duplicate vpn2 at 3.
        bus.write_enable = 1'b1;
        bus.write_index  = 4'd2;
        bus.write_data   = e2;
        tick();
        bus.write_index  = 4'd3;
        bus.write_data   = e3;
        tick();
        bus.write_enable  = 1'b0;
        bus.probe_request = mk_req(19'h00777, 1'b0, 8'h55);
        bus.fetch_request = mk_req(19'h00777, 1'b0, 8'hEE);
        bus.data_request  = mk_req(19'h00777, 1'b1, 8'h42);
        expect_res("probe_lowest_wins", KProbe, mk_hit(4'd2, e2.even_page));
        expect_res("fetch_global_any_asid", KFetch, mk_hit(4'd2, e2.even_page));
        expect_res("data_global_odd_invalid", KData, mk_hit(4'd2, e2.odd_page));
        tick();

        // Write/read ordering at index 7.
        bus.write_enable = 1'b1;
        bus.write_index  = 4'd7;
        bus.write_data   = e7;
        bus.read_index   = 4'd7;
        expect_entry("wi7_same_cycle_old", '0);
        tick();
        bus.write_enable = 1'b0;
        expect_entry("wi7_next_cycle_new", e7);
        tick();

        // TLBWR when Random is 9.
        for (int i = 0; i < 16 && exp_rand != 4'd9; i++) tick();
        bus.write_enable     = 1'b1;
        bus.write_use_random = 1'b1;
        bus.write_index      = 4'd4;
        bus.write_data       = e9;
        expect_scalar("wr_random_is_9", KRandom, 4'd9);
        tick();
        bus.write_enable     = 1'b0;
        bus.write_use_random = 1'b0;
        bus.read_index       = 4'd9;
        expect_entry("wr_landed_9", e9);
        expect_scalar("wr_random_after", KRandom, exp_rand);
        tick();
        bus.read_index = 4'd4;
        expect_entry("wr_not_at_write_index", '0);
        tick();

        // Mid-sweep reset.
        reset = 1'b0;
        model_ready = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        reset = 1'b0;
        tick();
        expect_scalar("midreset_busy", KBusy, 1);
        expect_scalar("midreset_random", KRandom, 4'd15);
        bus.probe_request = mk_req(19'h12345, 1'b0, 8'h3A);
        expect_res("midreset_probe", KProbe, miss);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            expect_scalar("resweep_busy", KBusy, 1);
            // Write attempt while busy, after entry 1 has already been swept.
            bus.write_enable = (i == 5);
            bus.write_index  = 4'd1;
            bus.write_data   = e1;
            tick();
        end
        bus.write_enable = 1'b0;
        expect_scalar("resweep_done", KBusy, 0);
        expect_scalar("resweep_random_held", KRandom, 4'd15);
        bus.read_index    = 4'd1;
        bus.probe_request = mk_req(19'h01001, 1'b0, 8'h01);
        bus.fetch_request = mk_req(19'h12345, 1'b0, 8'h3A);
        bus.data_request  = mk_req(19'h07007, 1'b0, 8'h07);
        expect_entry("busy_write_dropped", '0);
        expect_res("busy_write_probe_miss", KProbe, miss);
        expect_res("resweep_cleared_e5", KFetch, miss);
        expect_res("resweep_cleared_e7", KData, miss);
        tick();
        bus.read_index = 4'd7;
        expect_entry("resweep_read7", '0);
        tick();
        tick();

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
